apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares the master-side port of the APB-to-APB bridge (apb_bridge) among NUM_REQ requesters.
- Arbitrates round-robin and sequences each granted request through the setup and access phases (strb, then strb+trnsfr).
- Returns read data and completion status to the winning requester, and aborts hung transfers with a timeout.
- Sits between the system-side masters and the bridge's master channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
AW, `ADDR_WIDTH, address width
DW, `DATA_WIDTH, data width
TIMEOUT, 16, max ACCESS cycles without ready before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
req  in  NUM_REQ  per-requester transfer request, level, held until done
req_wr  in  NUM_REQ  per-requester direction (1=write)
req_addr  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
gnt  out  NUM_REQ  one-hot grant, high from SETUP through ACCESS
done  out  NUM_REQ  one-cycle completion pulse to granted requester
err  out  1  high with done when transfer timed out
rdata  out  DW  read data, valid in done cycle
strb  out  1  to bridge: transfer select
trnsfr  out  1  to bridge: access/enable phase
wr  out  1  to bridge: direction
address  out  AW  to bridge: address
data_in  out  DW  to bridge: write data
data_out  in  DW  from bridge: read data
ready  in  1  from bridge: access phase completes

Behaviour:
- All outputs registered.
- Reset (rst=1 at posedge): state=IDLE, rr pointer=0, timer=0. gnt, done, err, rdata, strb, trnsfr, wr, address, data_in all 0. rst wins over all other events.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req, select the first asserted index searching ptr, ptr+1, ... mod NUM_REQ.
  - Latch that requester's wr/addr/wdata into wr/address/data_in.
  - Set gnt[g]=1, strb=1, trnsfr=0; go to SETUP.
  - No req: remain in IDLE, outputs unchanged at 0.
- SETUP: exactly one cycle. Set trnsfr=1, timer=0, go to ACCESS. ready is ignored here.
- ACCESS: strb, trnsfr, wr, address and data_in are held stable.
  - ready=1: if wr=0, rdata<=data_out. done[g]=1, err=0, strb=trnsfr=0, gnt=0, ptr<=(g+1) mod NUM_REQ; go to DONE.
  - ready=0 and timer==TIMEOUT-1: same exit, but err=1 and rdata<=0.
  - Otherwise timer++.
- DONE: one turnaround cycle.
  - done/err are visible this cycle only and cleared at the next edge.
  - Arbitration is not evaluated; the requester must drop req here unless it wants a new transfer, which is then arbitrated from IDLE.
  - Go to IDLE.
- Latency: req seen in IDLE cycle 0; strb in cycle 1; trnsfr in cycle 2; ready=1 in cycle 2 gives done in cycle 3. Minimum 4 cycles per transfer, including DONE.
- Payload is sampled only at grant. Later changes to req_wr/req_addr/req_wdata are ignored.
- Requester dropping req mid-transfer: the transfer still completes and done still pulses.
- rdata holds its value until the next completion. Write completions leave rdata unchanged.
- Reset mid-transfer: strb/trnsfr drop at the next edge, no done pulse, ptr returns to 0.
- gnt is one-hot or zero at all times; done is never asserted for more than one requester.

Test Plan:
1. Write: req[1]=1, wr=1, addr=0x10, wdata=0xA5; ready=1 in the first ACCESS cycle -> strb cycle 1, trnsfr cycle 2, address=0x10/data_in=0xA5 stable cycles 1-2, done[1] cycle 3, err=0.
2. Read with waits: req[0], wr=0, addr=0x20; ready held low 2 ACCESS cycles, data_out=0x3C when ready=1 -> done[0] and rdata=0x3C in cycle 5, trnsfr high cycles 2-4.
3. Round-robin: all four req held from reset, ready=1 in the first ACCESS cycle -> grant order 0,1,2,3,0 with done every 4 cycles; gnt never multi-hot.
4. Pointer skip: after requester 2 completes (ptr=3), req[0] and req[2] asserted together -> requester 0 granted first, then 2.
5. Timeout: TIMEOUT=16, ready tied 0 -> ACCESS for 16 cycles (cycles 2-17), done+err in cycle 18, rdata=0, next request arbitrated normally.
6. Reset mid-ACCESS: rst=1 during cycle 3 of a waited transfer -> cycle 4 all outputs 0, no done pulse; next request from requester 3 with req[0] also high -> requester 0 granted (ptr=0).

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares the bridge's master channel among NUM_REQ requesters,
// sequencing each grant through SETUP/ACCESS and aborting hung transfers after TIMEOUT cycles.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_master_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = `ADDR_WIDTH,
   parameter int DW      = `DATA_WIDTH,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_wr,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    done,
   output logic                  err,
   output logic [DW-1:0]         rdata,
   output logic                  strb,
   output logic                  trnsfr,
   output logic                  wr,
   output logic [AW-1:0]         address,
   output logic [DW-1:0]         data_in,
   input  logic [DW-1:0]         data_out,
   input  logic                  ready
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]         state_q,   state_d;
   logic [PW-1:0]      ptr_q,     ptr_d;
   logic [PW-1:0]      gidx_q,    gidx_d;
   logic [TW-1:0]      timer_q,   timer_d;
   logic [NUM_REQ-1:0] gnt_q,     gnt_d;
   logic [NUM_REQ-1:0] done_q,    done_d;
   logic               err_q,     err_d;
   logic [DW-1:0]      rdata_q,   rdata_d;
   logic               strb_q,    strb_d;
   logic               trnsfr_q,  trnsfr_d;
   logic               wr_q,      wr_d;
   logic [AW-1:0]      address_q, address_d;
   logic [DW-1:0]      data_in_q, data_in_d;

   logic [NUM_REQ-1:0] req_rot;
   logic [PW:0]        arb_sum;
   logic [PW-1:0]      arb_idx;
   logic               arb_found;
   logic [NUM_REQ-1:0] arb_gnt;
   logic               sel_wr;
   logic [AW-1:0]      sel_addr;
   logic [DW-1:0]      sel_wdata;
   logic [PW-1:0]      ptr_inc;

   // Rotating the request vector by ptr turns round-robin into a fixed-priority search
   // from bit 0; the winner's index is then ptr + offset, wrapped at NUM_REQ.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      req_rot   = NUM_REQ'({req, req} >> ptr_q);
      arb_found = 1'b0;
      arb_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!arb_found && req_rot[k]) begin
            arb_found = 1'b1;
            arb_sum   = {1'b0, ptr_q} + (PW+1)'(k);
         end
      end
      if (arb_sum >= (PW+1)'(NUM_REQ)) begin
         arb_sum = arb_sum - (PW+1)'(NUM_REQ);
      end
      arb_idx = arb_sum[PW-1:0];
      arb_gnt = NUM_REQ'(1) << arb_idx;
   end

   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arb_idx == PW'(k)) begin
            sel_wr    = req_wr[k];
            sel_addr  = req_addr[k*AW +: AW];
            sel_wdata = req_wdata[k*DW +: DW];
         end
      end
   end

   assign ptr_inc = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gidx_d    = gidx_q;
      timer_d   = timer_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      strb_d    = strb_q;
      trnsfr_d  = trnsfr_q;
      wr_d      = wr_q;
      address_d = address_q;
      data_in_d = data_in_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               state_d   = S_SETUP;
               gidx_d    = arb_idx;
               gnt_d     = arb_gnt;
               strb_d    = 1'b1;
               trnsfr_d  = 1'b0;
               wr_d      = sel_wr;
               address_d = sel_addr;
               data_in_d = sel_wdata;
            end
         end
         S_SETUP: begin
            trnsfr_d = 1'b1;
            timer_d  = '0;
            state_d  = S_ACCESS;
         end
         S_ACCESS: begin
            if (ready || (timer_q == TIMER_LAST)) begin
               // A timed-out transfer reports err and clears rdata even for writes.
               done_d   = gnt_q;
               err_d    = !ready;
               if (!ready) begin
                  rdata_d = '0;
               end else if (!wr_q) begin
                  rdata_d = data_out;
               end
               strb_d   = 1'b0;
               trnsfr_d = 1'b0;
               gnt_d    = '0;
               ptr_d    = ptr_inc;
               state_d  = S_DONE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         timer_q   <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         strb_q    <= 1'b0;
         trnsfr_q  <= 1'b0;
         wr_q      <= 1'b0;
         address_q <= '0;
         data_in_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gidx_q    <= gidx_d;
         timer_q   <= timer_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         strb_q    <= strb_d;
         trnsfr_q  <= trnsfr_d;
         wr_q      <= wr_d;
         address_q <= address_d;
         data_in_q <= data_in_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rdata   = rdata_q;
   assign strb    = strb_q;
   assign trnsfr  = trnsfr_q;
   assign wr      = wr_q;
   assign address = address_q;
   assign data_in = data_in_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: cycle-exact checks of grant, phase and completion timing.
module tb_apb_master_arbiter;

   localparam int NUM_REQ = 4;
   localparam int AW      = 16;
   localparam int DW      = 16;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_wr;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*DW-1:0] req_wdata;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    done;
   logic                  err;
   logic [DW-1:0]         rdata;
   logic                  strb;
   logic                  trnsfr;
   logic                  wr;
   logic [AW-1:0]         address;
   logic [DW-1:0]         data_in;
   logic [DW-1:0]         data_out;
   logic                  ready;

   logic          wr_arr    [NUM_REQ];
   logic [AW-1:0] addr_arr  [NUM_REQ];
   logic [DW-1:0] wdata_arr [NUM_REQ];

   int n_cmp = 0;
   int n_bad = 0;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign req_wr[g]              = wr_arr[g];
      assign req_addr[g*AW +: AW]   = addr_arr[g];
      assign req_wdata[g*DW +: DW]  = wdata_arr[g];
   end

   apb_master_arbiter #(
      .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .strb(strb), .trnsfr(trnsfr), .wr(wr), .address(address), .data_in(data_in),
      .data_out(data_out), .ready(ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_payload(input logic [1:0] i, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
      wr_arr[i]    = w;
      addr_arr[i]  = a;
      wdata_arr[i] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b0001;
      set_payload(2'd0, 1'b1, 16'h1111, 16'h2222);
      step();
      step();
      mid();
      n_cmp++; if ({gnt, done, err, strb, trnsfr, wr} !== 11'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want %b", {gnt, done, err, strb, trnsfr, wr}, 11'b0); end
      n_cmp++; if ({address, data_in, rdata} !== 48'h0) begin
         n_bad++; $display("FAIL reset_data: got %h want %h", {address, data_in, rdata}, 48'h0); end
      req = '0;
      step();
      rst = 1'b0;
      mid();
      n_cmp++; if ({gnt, strb, trnsfr} !== 6'b0) begin
         n_bad++; $display("FAIL reset_idle: got %b want %b", {gnt, strb, trnsfr}, 6'b0); end
      step();
   endtask

   task automatic test_write();
      set_payload(2'd1, 1'b1, 16'h0010, 16'h00A5);
      req = 4'b0010;
      mid();
      n_cmp++; if ({gnt, strb, trnsfr} !== 6'b0) begin
         n_bad++; $display("FAIL wr_c0: got %b want %b", {gnt, strb, trnsfr}, 6'b0); end
      step();
      set_payload(2'd1, 1'b0, 16'h0077, 16'h5A5A);
      mid();
      n_cmp++; if ({gnt, strb, trnsfr, wr} !== 7'b0010_101) begin
         n_bad++; $display("FAIL wr_c1_ctrl: got %b want %b", {gnt, strb, trnsfr, wr}, 7'b0010_101); end
      n_cmp++; if ({address, data_in} !== 32'h0010_00A5) begin
         n_bad++; $display("FAIL wr_c1_data: got %h want %h", {address, data_in}, 32'h0010_00A5); end
      step();
      ready = 1'b1;
      mid();
      n_cmp++; if ({gnt, strb, trnsfr, wr, done} !== 11'b0010_111_0000) begin
         n_bad++; $display("FAIL wr_c2_ctrl: got %b want %b", {gnt, strb, trnsfr, wr, done}, 11'b0010_111_0000); end
      n_cmp++; if ({address, data_in} !== 32'h0010_00A5) begin
         n_bad++; $display("FAIL wr_c2_data: got %h want %h", {address, data_in}, 32'h0010_00A5); end
      step();
      ready = 1'b0;
      req   = '0;
      mid();
      n_cmp++; if ({done, err, gnt, strb, trnsfr} !== 11'b0010_0_0000_00) begin
         n_bad++; $display("FAIL wr_c3_done: got %b want %b", {done, err, gnt, strb, trnsfr}, 11'b0010_0_0000_00); end
      n_cmp++; if (rdata !== 16'h0) begin
         n_bad++; $display("FAIL wr_c3_rdata: got %h want %h", rdata, 16'h0); end
      step();
      mid();
      n_cmp++; if ({done, err} !== 5'b0) begin
         n_bad++; $display("FAIL wr_c4_clear: got %b want %b", {done, err}, 5'b0); end
      step();
   endtask

   task automatic test_read_wait();
      set_payload(2'd0, 1'b0, 16'h0020, 16'h0000);
      req      = 4'b0001;
      data_out = 16'h0000;
      step();
      mid();
      n_cmp++; if ({gnt, strb, trnsfr, wr, address} !== {7'b0001_100, 16'h0020}) begin
         n_bad++; $display("FAIL rd_c1: got %h want %h", {gnt, strb, trnsfr, wr, address}, {7'b0001_100, 16'h0020}); end
      for (int c = 2; c <= 4; c++) begin
         step();
         if (c == 3) req = '0;
         if (c == 4) begin ready = 1'b1; data_out = 16'h003C; end
         mid();
         n_cmp++; if ({gnt, trnsfr, done} !== 9'b0001_1_0000) begin
            n_bad++; $display("FAIL rd_c%0d_access: got %b want %b", c, {gnt, trnsfr, done}, 9'b0001_1_0000); end
      end
      step();
      ready    = 1'b0;
      data_out = 16'hDEAD;
      mid();
      n_cmp++; if ({done, err, trnsfr} !== 6'b0001_0_0) begin
         n_bad++; $display("FAIL rd_c5_done: got %b want %b", {done, err, trnsfr}, 6'b0001_0_0); end
      n_cmp++; if (rdata !== 16'h003C) begin
         n_bad++; $display("FAIL rd_c5_rdata: got %h want %h", rdata, 16'h003C); end
      step();
      mid();
      n_cmp++; if ({done, rdata} !== {4'b0, 16'h003C}) begin
         n_bad++; $display("FAIL rd_c6_hold: got %h want %h", {done, rdata}, {4'b0, 16'h003C}); end
      step();
   endtask

   task automatic test_timeout();
      set_payload(2'd1, 1'b0, 16'h0030, 16'h0000);
      req      = 4'b0010;
      data_out = 16'hBEEF;
      ready    = 1'b0;
      step();
      mid();
      n_cmp++; if ({gnt, strb, trnsfr} !== 6'b0010_10) begin
         n_bad++; $display("FAIL to_c1: got %b want %b", {gnt, strb, trnsfr}, 6'b0010_10); end
      for (int c = 2; c <= 17; c++) begin
         step();
         mid();
         n_cmp++; if ({strb, trnsfr, done, err} !== 7'b11_0000_0) begin
            n_bad++; $display("FAIL to_c%0d_access: got %b want %b", c, {strb, trnsfr, done, err}, 7'b11_0000_0); end
      end
      step();
      req = '0;
      mid();
      n_cmp++; if ({done, err, strb, trnsfr, gnt} !== 11'b0010_1_00_0000) begin
         n_bad++; $display("FAIL to_c18_done: got %b want %b", {done, err, strb, trnsfr, gnt}, 11'b0010_1_00_0000); end
      n_cmp++; if (rdata !== 16'h0) begin
         n_bad++; $display("FAIL to_c18_rdata: got %h want %h", rdata, 16'h0); end
      step();
      set_payload(2'd2, 1'b1, 16'h0040, 16'h1234);
      req   = 4'b0100;
      ready = 1'b1;
      mid();
      n_cmp++; if ({done, err} !== 5'b0) begin
         n_bad++; $display("FAIL to_c19_clear: got %b want %b", {done, err}, 5'b0); end
      step();
      mid();
      n_cmp++; if ({gnt, strb, address, data_in} !== {4'b0100, 1'b1, 16'h0040, 16'h1234}) begin
         n_bad++; $display("FAIL to_next_grant: got %h want %h", {gnt, strb, address, data_in}, {4'b0100, 1'b1, 16'h0040, 16'h1234}); end
      step();
      step();
      req   = '0;
      ready = 1'b0;
      mid();
      n_cmp++; if ({done, err, rdata} !== {4'b0100, 1'b0, 16'h0000}) begin
         n_bad++; $display("FAIL to_next_done: got %h want %h", {done, err, rdata}, {4'b0100, 1'b0, 16'h0000}); end
      step();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      for (int i = 0; i < NUM_REQ; i++) begin
         set_payload(2'(i), 1'b1, 16'h0100 + 16'(i), 16'h0A00 + 16'(i));
      end
      rst   = 1'b1;
      req   = 4'b1111;
      ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         exp = 4'b0001 << ((c / 4) % 4);
         mid();
         n_cmp++; if (!$onehot0(gnt) || !$onehot0(done)) begin
            n_bad++; $display("FAIL rr_c%0d_onehot: got gnt=%b done=%b want one-hot or zero", c, gnt, done); end
         if (c % 4 == 1) begin
            n_cmp++; if ({gnt, address} !== {exp, 16'h0100 + 16'((c / 4) % 4)}) begin
               n_bad++; $display("FAIL rr_c%0d_grant: got %h want %h", c, {gnt, address}, {exp, 16'h0100 + 16'((c / 4) % 4)}); end
         end
         if (c % 4 == 3) begin
            n_cmp++; if (done !== exp) begin
               n_bad++; $display("FAIL rr_c%0d_done: got %b want %b", c, done, exp); end
         end else begin
            n_cmp++; if (done !== 4'b0) begin
               n_bad++; $display("FAIL rr_c%0d_nodone: got %b want %b", c, done, 4'b0); end
         end
         if (c == 19) begin
            req   = '0;
            ready = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_ptr_skip();
      ready = 1'b1;
      req   = 4'b0100;
      step();
      mid();
      n_cmp++; if (gnt !== 4'b0100) begin
         n_bad++; $display("FAIL skip_first_grant: got %b want %b", gnt, 4'b0100); end
      step();
      step();
      req = '0;
      mid();
      n_cmp++; if (done !== 4'b0100) begin
         n_bad++; $display("FAIL skip_first_done: got %b want %b", done, 4'b0100); end
      step();
      req = 4'b0101;
      step();
      mid();
      n_cmp++; if (gnt !== 4'b0001) begin
         n_bad++; $display("FAIL skip_grant0: got %b want %b", gnt, 4'b0001); end
      step();
      step();
      req = 4'b0100;
      mid();
      n_cmp++; if (done !== 4'b0001) begin
         n_bad++; $display("FAIL skip_done0: got %b want %b", done, 4'b0001); end
      step();
      step();
      mid();
      n_cmp++; if (gnt !== 4'b0100) begin
         n_bad++; $display("FAIL skip_grant2: got %b want %b", gnt, 4'b0100); end
      step();
      step();
      req   = '0;
      ready = 1'b0;
      mid();
      n_cmp++; if (done !== 4'b0100) begin
         n_bad++; $display("FAIL skip_done2: got %b want %b", done, 4'b0100); end
      step();
   endtask

   task automatic test_reset_mid();
      set_payload(2'd3, 1'b0, 16'h0300, 16'h0000);
      req   = 4'b1000;
      ready = 1'b0;
      step();
      mid();
      n_cmp++; if (gnt !== 4'b1000) begin
         n_bad++; $display("FAIL rstm_grant3: got %b want %b", gnt, 4'b1000); end
      step();
      step();
      rst = 1'b1;
      mid();
      n_cmp++; if ({strb, trnsfr} !== 2'b11) begin
         n_bad++; $display("FAIL rstm_c3_access: got %b want %b", {strb, trnsfr}, 2'b11); end
      step();
      rst = 1'b0;
      req = 4'b1001;
      set_payload(2'd0, 1'b1, 16'h0500, 16'h0055);
      mid();
      n_cmp++; if ({gnt, done, err, strb, trnsfr, wr} !== 12'b0) begin
         n_bad++; $display("FAIL rstm_c4_ctrl: got %b want %b", {gnt, done, err, strb, trnsfr, wr}, 12'b0); end
      n_cmp++; if ({address, data_in, rdata} !== 48'h0) begin
         n_bad++; $display("FAIL rstm_c4_data: got %h want %h", {address, data_in, rdata}, 48'h0); end
      step();
      mid();
      n_cmp++; if ({gnt, done, address} !== {4'b0001, 4'b0000, 16'h0500}) begin
         n_bad++; $display("FAIL rstm_c5_grant0: got %h want %h", {gnt, done, address}, {4'b0001, 4'b0000, 16'h0500}); end
      step();
      ready = 1'b1;
      step();
      req   = '0;
      ready = 1'b0;
      mid();
      n_cmp++; if ({done, err} !== 5'b0001_0) begin
         n_bad++; $display("FAIL rstm_c7_done: got %b want %b", {done, err}, 5'b0001_0); end
      step();
   endtask

   initial begin
      rst      = 1'b1;
      req      = '0;
      ready    = 1'b0;
      data_out = '0;
      for (int i = 0; i < NUM_REQ; i++) set_payload(2'(i), 1'b0, '0, '0);
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_round_robin();
      test_ptr_skip();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
